// File: rtl/m2_block_fetch.sv
// m2_block_fetch: fetches one 8x8 block of pre-IDCT coefficients per Start
// from SRAM (one signed 16-bit value per word) and writes them, sign-extended
// to 32 bits, into the IDCT's dual-port RAM. Block order (Y, then U, then V,
// raster within each plane), plane offsets and strides are generated here.
//
// Ports:
//   Clock, Resetn        clock, asynchronous active-low reset
//   Start                fetch next block (sampled only when idle)
//   SRAM_address         read address (18 bit)
//   SRAM_read_data       read data, valid two cycles after its address
//   SRAM_we_n            tied high, read-only master
//   DPRAM_address        coefficient index row*8+col
//   DPRAM_write_data     sign-extended coefficient
//   DPRAM_we             write enable
//   Busy, Done           fetch in progress / one-cycle completion pulse
//   Block_plane/row/col  block being fetched (0 Y, 1 U, 2 V)
//   Last_block           with Done when the final V block completes
module m2_block_fetch #(
  parameter logic [17:0] PRE_IDCT_BASE = 18'd76800,
  parameter logic [17:0] U_OFFSET      = 18'd76800,
  parameter logic [17:0] V_OFFSET      = 18'd115200,
  parameter int unsigned Y_STRIDE      = 320,
  parameter int unsigned UV_STRIDE     = 160,
  parameter int unsigned Y_BLOCK_COLS  = 40,
  parameter int unsigned UV_BLOCK_COLS = 20,
  parameter int unsigned BLOCK_ROWS    = 30
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic        SRAM_we_n,
  output logic [5:0]  DPRAM_address,
  output logic [31:0] DPRAM_write_data,
  output logic        DPRAM_we,
  output logic        Busy,
  output logic        Done,
  output logic [1:0]  Block_plane,
  output logic [4:0]  Block_row,
  output logic [5:0]  Block_col,
  output logic        Last_block
);

  localparam logic [17:0] Y_STRIDE_A   = 18'(Y_STRIDE);
  localparam logic [17:0] UV_STRIDE_A  = 18'(UV_STRIDE);
  localparam logic [17:0] Y_STRIDE8    = 18'(8 * Y_STRIDE);
  localparam logic [17:0] UV_STRIDE8   = 18'(8 * UV_STRIDE);
  localparam logic [5:0]  Y_COL_LAST   = 6'(Y_BLOCK_COLS - 1);
  localparam logic [5:0]  UV_COL_LAST  = 6'(UV_BLOCK_COLS - 1);
  localparam logic [4:0]  ROW_LAST     = 5'(BLOCK_ROWS - 1);

  typedef enum logic [1:0] {
    S_BF_IDLE,
    S_BF_ISSUE,
    S_BF_DRAIN,
    S_BF_DONE
  } state_t;

  state_t      state, state_n;
  logic [5:0]  sample_cnt;
  logic        drain_cnt;
  logic [17:0] row_addr;        // address of sample (r,0) of current block
  logic [17:0] block_addr;      // address of sample (0,0) of current block
  logic [17:0] block_row_addr;  // address of sample (0,0) of column-0 block in this block row
  logic        p1_valid;
  logic [5:0]  p1_idx;
  logic [17:0] stride, stride8;
  logic [5:0]  col_last;

  always_comb begin
    stride   = (Block_plane == 2'd0) ? Y_STRIDE_A  : UV_STRIDE_A;
    stride8  = (Block_plane == 2'd0) ? Y_STRIDE8   : UV_STRIDE8;
    col_last = (Block_plane == 2'd0) ? Y_COL_LAST  : UV_COL_LAST;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= S_BF_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_BF_IDLE:  if (Start) state_n = S_BF_ISSUE;
      S_BF_ISSUE: if (sample_cnt == 6'd63) state_n = S_BF_DRAIN;
      S_BF_DRAIN: if (drain_cnt) state_n = S_BF_DONE;
      S_BF_DONE:  state_n = S_BF_IDLE;
      default:    state_n = S_BF_IDLE;
    endcase
  end

  always_comb begin
    SRAM_we_n        = 1'b1;
    Busy             = (state == S_BF_ISSUE) || (state == S_BF_DRAIN);
    Done             = (state == S_BF_DONE);
    Last_block       = Done && (Block_plane == 2'd2) &&
                       (Block_row == ROW_LAST) && (Block_col == UV_COL_LAST);
    // Read data arrives two cycles after its address, aligned with DPRAM_we.
    DPRAM_write_data = DPRAM_we ? {{16{SRAM_read_data[15]}}, SRAM_read_data} : '0;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      SRAM_address   <= '0;
      DPRAM_address  <= '0;
      DPRAM_we       <= 1'b0;
      p1_valid       <= 1'b0;
      p1_idx         <= '0;
      sample_cnt     <= '0;
      drain_cnt      <= 1'b0;
      row_addr       <= PRE_IDCT_BASE;
      block_addr     <= PRE_IDCT_BASE;
      block_row_addr <= PRE_IDCT_BASE;
      Block_plane    <= '0;
      Block_row      <= '0;
      Block_col      <= '0;
    end else begin
      // Two-stage delay from issued address to DPRAM write.
      p1_valid <= (state == S_BF_ISSUE);
      p1_idx   <= sample_cnt;
      DPRAM_we <= p1_valid;
      if (p1_valid) DPRAM_address <= p1_idx;

      unique case (state)
        S_BF_IDLE: begin
          if (Start) begin
            sample_cnt   <= '0;
            SRAM_address <= block_addr;
            row_addr     <= block_addr;
          end
        end
        S_BF_ISSUE: begin
          drain_cnt <= 1'b0;
          if (sample_cnt != 6'd63) begin
            sample_cnt <= sample_cnt + 6'd1;
            if (sample_cnt[2:0] == 3'd7) begin
              row_addr     <= row_addr + stride;
              SRAM_address <= row_addr + stride;
            end else begin
              SRAM_address <= SRAM_address + 18'd1;
            end
          end
        end
        S_BF_DRAIN: drain_cnt <= ~drain_cnt;
        S_BF_DONE: begin
          if (Block_col != col_last) begin
            Block_col  <= Block_col + 6'd1;
            block_addr <= block_addr + 18'd8;
          end else begin
            Block_col <= '0;
            if (Block_row != ROW_LAST) begin
              Block_row      <= Block_row + 5'd1;
              block_row_addr <= block_row_addr + stride8;
              block_addr     <= block_row_addr + stride8;
            end else begin
              Block_row <= '0;
              unique case (Block_plane)
                2'd0: begin
                  Block_plane    <= 2'd1;
                  block_row_addr <= PRE_IDCT_BASE + U_OFFSET;
                  block_addr     <= PRE_IDCT_BASE + U_OFFSET;
                end
                2'd1: begin
                  Block_plane    <= 2'd2;
                  block_row_addr <= PRE_IDCT_BASE + V_OFFSET;
                  block_addr     <= PRE_IDCT_BASE + V_OFFSET;
                end
                default: begin
                  Block_plane    <= 2'd0;
                  block_row_addr <= PRE_IDCT_BASE;
                  block_addr     <= PRE_IDCT_BASE;
                end
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_m2_block_fetch.sv
// Directed bench for m2_block_fetch with a two-cycle-latency SRAM model.
// Block rows are reduced to 2 (plane offsets scaled to match) so all plane
// wraps are reached in a short run; column geometry and strides are full size.
module tb_m2_block_fetch;

  localparam int          ROWS = 2;
  localparam logic [17:0] UOFF = 18'd5120;   // 2*8*320
  localparam logic [17:0] VOFF = 18'd7680;   // UOFF + 2*8*160

  logic        Clock, Resetn, Start;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic        SRAM_we_n;
  logic [5:0]  DPRAM_address;
  logic [31:0] DPRAM_write_data;
  logic        DPRAM_we, Busy, Done, Last_block;
  logic [1:0]  Block_plane;
  logic [4:0]  Block_row;
  logic [5:0]  Block_col;
  logic [15:0] sram_d1;

  int total = 0;
  int bad   = 0;
  int m_plane = 0, m_row = 0, m_col = 0;

  m2_block_fetch #(
    .U_OFFSET   (UOFF),
    .V_OFFSET   (VOFF),
    .BLOCK_ROWS (ROWS)
  ) dut (
    .Clock            (Clock),
    .Resetn           (Resetn),
    .Start            (Start),
    .SRAM_address     (SRAM_address),
    .SRAM_read_data   (SRAM_read_data),
    .SRAM_we_n        (SRAM_we_n),
    .DPRAM_address    (DPRAM_address),
    .DPRAM_write_data (DPRAM_write_data),
    .DPRAM_we         (DPRAM_we),
    .Busy             (Busy),
    .Done             (Done),
    .Block_plane      (Block_plane),
    .Block_row        (Block_row),
    .Block_col        (Block_col),
    .Last_block       (Last_block)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [15:0] sram_val(input logic [17:0] a);
    if (a == 18'd76805) return 16'hFF80;
    if (a == 18'd76806) return 16'h007F;
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  always @(posedge Clock) begin
    sram_d1        <= sram_val(SRAM_address);
    SRAM_read_data <= sram_d1;
  end

  function automatic int ncols(input int p);
    return (p == 0) ? 40 : 20;
  endfunction

  function automatic int pstride(input int p);
    return (p == 0) ? 320 : 160;
  endfunction

  function automatic int poff(input int p);
    return (p == 0) ? 0 : (p == 1) ? int'(UOFF) : int'(VOFF);
  endfunction

  function automatic logic [17:0] exp_addr(input int s);
    int v;
    v = 76800 + poff(m_plane) + (8 * m_row + s / 8) * pstride(m_plane)
        + 8 * m_col + s % 8;
    return 18'(v);
  endfunction

  function automatic bit is_last();
    return (m_plane == 2) && (m_row == ROWS - 1) && (m_col == 19);
  endfunction

  task automatic advance_model();
    m_col++;
    if (m_col == ncols(m_plane)) begin
      m_col = 0;
      m_row++;
      if (m_row == ROWS) begin
        m_row   = 0;
        m_plane = (m_plane + 1) % 3;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset();
    chk("rst_sram_addr", 32'(SRAM_address), 32'd0);
    chk("rst_we_n", 32'(SRAM_we_n), 32'd1);
    chk("rst_dp_addr", 32'(DPRAM_address), 32'd0);
    chk("rst_dp_data", DPRAM_write_data, 32'd0);
    chk("rst_dp_we", 32'(DPRAM_we), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_last", 32'(Last_block), 32'd0);
    chk("rst_plane", 32'(Block_plane), 32'd0);
    chk("rst_row", 32'(Block_row), 32'd0);
    chk("rst_col", 32'(Block_col), 32'd0);
  endtask

  // Entered at the negedge of an idle cycle; leaves at the negedge of the
  // idle cycle 68 cycles after the accepting edge.
  task automatic run_block(input bit hold, input bit pokes, input bit sext_chk);
    logic [15:0] d;
    Start = 1'b1;
    for (int j = 1; j <= 68; j++) begin
      @(posedge Clock);
      @(negedge Clock);
      if (!hold) Start = pokes && (j == 19 || j == 67);
      if (j == 68) begin
        chk("idle_busy", 32'(Busy), 32'd0);
        chk("idle_done", 32'(Done), 32'd0);
        chk("idle_we", 32'(DPRAM_we), 32'd0);
        advance_model();
        chk("next_plane", 32'(Block_plane), 32'(m_plane));
        chk("next_row", 32'(Block_row), 32'(m_row));
        chk("next_col", 32'(Block_col), 32'(m_col));
      end else begin
        chk("busy", 32'(Busy), 32'(j <= 66));
        chk("done", 32'(Done), 32'(j == 67));
        chk("last", 32'(Last_block), 32'((j == 67) && is_last()));
        chk("we_n", 32'(SRAM_we_n), 32'd1);
        chk("plane", 32'(Block_plane), 32'(m_plane));
        chk("row", 32'(Block_row), 32'(m_row));
        chk("col", 32'(Block_col), 32'(m_col));
        if (j <= 64) chk("sram_addr", 32'(SRAM_address), 32'(exp_addr(j - 1)));
        chk("dp_we", 32'(DPRAM_we), 32'((j >= 3) && (j <= 66)));
        if (j >= 3 && j <= 66) begin
          d = sram_val(exp_addr(j - 3));
          chk("dp_addr", 32'(DPRAM_address), 32'(j - 3));
          chk("dp_data", DPRAM_write_data, {{16{d[15]}}, d});
        end
        if (sext_chk && j == 8) chk("sext_neg", DPRAM_write_data, 32'hFFFFFF80);
        if (sext_chk && j == 9) chk("sext_pos", DPRAM_write_data, 32'h0000007F);
        if (sext_chk && j == 64) chk("blk0_last_addr", 32'(SRAM_address), 32'd79047);
      end
    end
  endtask

  initial begin
    Resetn = 1'b0;
    Start  = 1'b0;
    repeat (3) @(negedge Clock);
    check_reset();
    Resetn = 1'b1;
    @(negedge Clock);

    // Block 0 with Start pokes during ISSUE and Done, which must be ignored.
    run_block(1'b0, 1'b1, 1'b1);
    Start = 1'b0;
    repeat (3) begin
      @(negedge Clock);
      chk("ignored_start_busy", 32'(Busy), 32'd0);
    end

    // Remaining blocks back-to-back with Start held high; the last of these
    // is the final V block and the model then wraps to plane 0.
    for (int b = 1; b < 40 * ROWS + 2 * 20 * ROWS; b++) run_block(1'b1, 1'b0, 1'b0);
    Start = 1'b0;
    @(negedge Clock);
    chk("wrap_plane", 32'(Block_plane), 32'd0);

    run_block(1'b0, 1'b0, 1'b1);

    // Reset while sample 30 is on the address bus.
    Start = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0;
    repeat (30) @(negedge Clock);
    chk("pre_rst_addr", 32'(SRAM_address), 32'(exp_addr(30)));
    Resetn = 1'b0;
    #1;
    check_reset();
    @(negedge Clock);
    Resetn = 1'b1;
    m_plane = 0;
    m_row   = 0;
    m_col   = 0;
    @(negedge Clock);
    chk("post_rst_busy", 32'(Busy), 32'd0);
    run_block(1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
